// File: rtl/best_delay_readout_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// best_delay_pkg : shared types and constants for the delay-buffer readout
// Rev 1.0
// ============================================================================
package best_delay_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_VAL = 3'd1,
    ST_CAPTURE  = 3'd2,
    ST_STOP     = 3'd3,
    ST_REFILL   = 3'd4
  } state_t;

  localparam logic [3:0] HDR_MARKER    = 4'hA;
  localparam int         FRAME_W       = 36;
  localparam int         REFILL_CYCLES = 256;
  localparam int         STOP_CYCLES   = 2;

  function automatic logic [FRAME_W-1:0] make_header(input logic [11:0] evt_id,
                                                     input logic [3:0]  nbins);
    return {HDR_MARKER, evt_id, 4'h0, nbins, 12'h000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/best_delay_readout_ctrl_if.sv
`default_nettype none
// ============================================================================
// best_delay_readout_ctrl_if : valid/ready readout stream with end-of-event tag
// Rev 1.0
// ============================================================================
interface best_delay_readout_ctrl_if;
  import best_delay_pkg::*;

  logic [FRAME_W-1:0] rd_data;
  logic               rd_valid;
  logic               rd_ready;
  logic               rd_last;

  modport master (output rd_data, output rd_valid, output rd_last, input rd_ready);
  modport slave  (input rd_data, input rd_valid, input rd_last, output rd_ready);

endinterface
`default_nettype wire

// File: rtl/best_delay_readout_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// readout_fifo : first-word-fall-through FIFO with retro-tag of the tail word
// Rev 1.0
// ============================================================================
module readout_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 32
) (
  input  wire                      clk,
  input  wire                      rst_n,
  input  wire                      wr_en,
  input  wire  [WIDTH-1:0]         wr_data,
  input  wire                      mark_last,
  input  wire                      hold_tail,
  input  wire                      rd_ready,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0]    C_ONE   = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW-1:0]    w_tail;
  logic             w_push;
  logic             w_pop;

  assign w_tail = r_wr_ptr - AW'(1);
  // The youngest word of an open event stays hidden so it can still be tagged last.
  assign rd_valid = hold_tail ? (r_count > C_ONE) : (r_count != '0);
  assign rd_data  = rd_valid ? r_mem[r_rd_ptr] : '0;
  assign free     = C_DEPTH - r_count;
  assign w_push   = wr_en && (r_count != C_DEPTH);
  assign w_pop    = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (mark_last && (r_count != '0)) begin
      r_mem[w_tail][WIDTH-1] <= 1'b1;
    end
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/best_delay_readout_ctrl.sv
`default_nettype none
// ============================================================================
// best_delay_readout_ctrl : L1A-triggered readout of a delay buffer into a FIFO
// Rev 1.0
// ============================================================================
module best_delay_readout_ctrl
  import best_delay_pkg::*;
#(
  parameter int VAL_LAT    = 2,
  parameter int FIFO_DEPTH = 32
) (
  input  wire                         clk,
  input  wire                         rst_n,
  input  wire                         l1a,
  input  wire                         valorr,
  input  wire  [FRAME_W-1:0]          buf_dout,
  input  wire  [3:0]                  nbins,
  input  wire  [7:0]                  cfg_delay,
  input  wire                         cfg_wr,
  output logic [7:0]                  delay,
  output logic                        trig_stop,
  output logic                        we,
  best_delay_readout_ctrl_if.master   rd,
  output logic                        busy,
  output logic [11:0]                 l1a_cnt,
  output logic [7:0]                  drop_cnt
);

  localparam int         AW            = $clog2(FIFO_DEPTH);
  localparam logic [7:0] C_VAL_LOAD    = 8'(VAL_LAT - 1);
  localparam logic [7:0] C_STOP_LOAD   = 8'(STOP_CYCLES - 1);
  localparam logic [7:0] C_REFILL_LOAD = 8'(REFILL_CYCLES - 1);

  state_t             r_state;
  state_t             w_next;
  logic [7:0]         r_cnt;
  logic [7:0]         w_cnt_nxt;
  logic               r_init;
  logic [11:0]        r_evt_id;
  logic               w_fifo_wr;
  logic [FRAME_W-1:0] w_fifo_word;
  logic               w_fifo_last;
  logic               w_mark_last;
  logic               w_drop_evt;
  logic               w_evt_load;
  logic               w_l1a_drop;
  logic [AW:0]        w_free;
  logic               w_room;
  logic [FRAME_W:0]   w_head;
  logic [1:0]         w_drop_inc;
  logic [8:0]         w_drop_sum;

  assign w_room = (32'(w_free) >= (32'(nbins) + 32'd2));

  always_comb begin
    w_next      = r_state;
    w_cnt_nxt   = r_cnt;
    w_fifo_wr   = 1'b0;
    w_fifo_word = '0;
    w_fifo_last = 1'b0;
    w_mark_last = 1'b0;
    w_drop_evt  = 1'b0;
    w_evt_load  = 1'b0;
    if (cfg_wr) begin
      // Abort: the word of this cycle is not written; the tail becomes end-of-event.
      w_next      = ST_STOP;
      w_cnt_nxt   = C_STOP_LOAD;
      w_mark_last = (r_state == ST_CAPTURE);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_init) begin
            w_next    = ST_STOP;
            w_cnt_nxt = C_STOP_LOAD;
          end else if (l1a) begin
            w_next     = ST_WAIT_VAL;
            w_cnt_nxt  = C_VAL_LOAD;
            w_evt_load = 1'b1;
          end
        end
        ST_WAIT_VAL: begin
          if (r_cnt != 8'd0) begin
            w_cnt_nxt = r_cnt - 8'd1;
          end else if (!valorr) begin
            w_next = ST_IDLE;
          end else if (w_room) begin
            w_fifo_wr   = 1'b1;
            w_fifo_word = make_header(r_evt_id, nbins);
            w_cnt_nxt   = {4'd0, nbins};
            w_next      = ST_CAPTURE;
          end else begin
            w_drop_evt = 1'b1;
            w_next     = ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          w_fifo_wr   = 1'b1;
          w_fifo_word = buf_dout;
          if (r_cnt == 8'd0) begin
            w_fifo_last = 1'b1;
            w_next      = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
        ST_STOP: begin
          if (r_cnt == 8'd0) begin
            w_next    = ST_REFILL;
            w_cnt_nxt = C_REFILL_LOAD;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
        ST_REFILL: begin
          if (r_cnt == 8'd0) begin
            w_next = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
        default: begin
          w_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_init  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_init  <= 1'b0;
    end
  end

  assign w_l1a_drop = l1a && !w_evt_load;
  assign w_drop_inc = {1'b0, w_l1a_drop} + {1'b0, w_drop_evt};
  assign w_drop_sum = {1'b0, drop_cnt} + {7'd0, w_drop_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay    <= 8'd0;
      l1a_cnt  <= 12'd0;
      drop_cnt <= 8'd0;
      r_evt_id <= 12'd0;
    end else begin
      if (cfg_wr) begin
        delay <= cfg_delay;
      end
      if (l1a) begin
        l1a_cnt <= l1a_cnt + 12'd1;
      end
      if (w_evt_load) begin
        r_evt_id <= l1a_cnt + 12'd1;
      end
      drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  // r_init covers reset and the first cycle after it, before STOP is entered.
  assign trig_stop = r_init || (r_state == ST_STOP);
  assign we        = !r_init && (r_state != ST_STOP);
  assign busy      = r_init || (r_state != ST_IDLE);

  readout_fifo #(
    .WIDTH (FRAME_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (w_fifo_wr),
    .wr_data   ({w_fifo_last, w_fifo_word}),
    .mark_last (w_mark_last),
    .hold_tail (r_state == ST_CAPTURE),
    .rd_ready  (rd.rd_ready),
    .rd_valid  (rd.rd_valid),
    .rd_data   (w_head),
    .free      (w_free)
  );

  assign rd.rd_data = w_head[FRAME_W-1:0];
  assign rd.rd_last = w_head[FRAME_W];

endmodule
`default_nettype wire

// File: tb/tb_best_delay_readout_ctrl.sv
`default_nettype none
// ============================================================================
// tb_best_delay_readout_ctrl : directed self-checking bench for the readout ctrl
// Rev 1.0
// ============================================================================
module tb_best_delay_readout_ctrl;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        l1a       = 1'b0;
  logic        valorr    = 1'b0;
  logic [35:0] buf_dout  = '0;
  logic [3:0]  nbins     = 4'd0;
  logic [7:0]  cfg_delay = 8'd0;
  logic        cfg_wr    = 1'b0;
  logic [7:0]  delay;
  logic        trig_stop;
  logic        we;
  logic        busy;
  logic [11:0] l1a_cnt;
  logic [7:0]  drop_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] got[$];

  best_delay_readout_ctrl_if rd();

  best_delay_readout_ctrl #(.VAL_LAT(2), .FIFO_DEPTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .l1a       (l1a),
    .valorr    (valorr),
    .buf_dout  (buf_dout),
    .nbins     (nbins),
    .cfg_delay (cfg_delay),
    .cfg_wr    (cfg_wr),
    .delay     (delay),
    .trig_stop (trig_stop),
    .we        (we),
    .rd        (rd),
    .busy      (busy),
    .l1a_cnt   (l1a_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle i of a sequence drives buf_dout = 36'h5C0DE0000 + i.
  task automatic run_seq(input int ncyc, input logic [63:0] l1a_at,
                         input logic [63:0] val_at, input int cfg_at);
    for (int i = 0; i < ncyc; i++) begin
      l1a      = l1a_at[i];
      valorr   = val_at[i];
      cfg_wr   = (i == cfg_at);
      buf_dout = 36'h5C0DE0000 + 36'(i);
      if (rd.rd_valid && rd.rd_ready) got.push_back({rd.rd_last, rd.rd_data});
      step();
    end
    l1a = 1'b0; valorr = 1'b0; cfg_wr = 1'b0;
  endtask

  task automatic drain();
    int idle = 0;
    rd.rd_ready = 1'b1;
    for (int c = 0; c < 200 && idle < 4; c++) begin
      if (rd.rd_valid) begin
        got.push_back({rd.rd_last, rd.rd_data});
        idle = 0;
      end else begin
        idle++;
      end
      step();
    end
    rd.rd_ready = 1'b0;
  endtask

  task automatic reset_dut();
    int n = 0;
    l1a = 1'b0; valorr = 1'b0; cfg_wr = 1'b0; rd.rd_ready = 1'b0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    while (busy !== 1'b0 && n < 400) begin
      step();
      n++;
    end
    if (busy !== 1'b0) begin
      n_cmp++; n_err++;
      $display("FAIL reset_wait: busy=%b after %0d cycles, required 0", busy, n);
    end
    got.delete();
  endtask

  task automatic test_reset();
    int n = 0;
    rd.rd_ready = 1'b0;
    rst_n = 1'b0;
    step(); step();
    n_cmp++; if (rd.rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_rd_valid: got %b required 0", rd.rd_valid); end
    n_cmp++; if (rd.rd_last !== 1'b0) begin n_err++; $display("FAIL rst_rd_last: got %b required 0", rd.rd_last); end
    n_cmp++; if (rd.rd_data !== 36'h0) begin n_err++; $display("FAIL rst_rd_data: got %h required 0", rd.rd_data); end
    n_cmp++; if (delay !== 8'd0) begin n_err++; $display("FAIL rst_delay: got %0d required 0", delay); end
    n_cmp++; if (trig_stop !== 1'b1) begin n_err++; $display("FAIL rst_trig_stop: got %b required 1", trig_stop); end
    n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b required 0", we); end
    n_cmp++; if (l1a_cnt !== 12'd0) begin n_err++; $display("FAIL rst_l1a_cnt: got %0d required 0", l1a_cnt); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL rst_drop_cnt: got %0d required 0", drop_cnt); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b required 1", busy); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (trig_stop !== 1'b1 || we !== 1'b0) begin n_err++; $display("FAIL stop_cyc1: trig_stop=%b we=%b required 1 0", trig_stop, we); end
    step();
    n_cmp++; if (trig_stop !== 1'b1 || we !== 1'b0) begin n_err++; $display("FAIL stop_cyc2: trig_stop=%b we=%b required 1 0", trig_stop, we); end
    step();
    n_cmp++; if (trig_stop !== 1'b0 || we !== 1'b1) begin n_err++; $display("FAIL refill_start: trig_stop=%b we=%b required 0 1", trig_stop, we); end
    while (busy === 1'b1 && n < 400) begin
      n++;
      step();
    end
    n_cmp++; if (n !== 256) begin n_err++; $display("FAIL refill_len: got %0d busy cycles required 256", n); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_refill_busy: got %b required 0", busy); end
  endtask

  task automatic test_basic_event();
    logic [36:0] exp_w [5];
    exp_w[0] = {1'b0, 36'hA00103000};
    exp_w[1] = {1'b0, 36'h5C0DE0003};
    exp_w[2] = {1'b0, 36'h5C0DE0004};
    exp_w[3] = {1'b0, 36'h5C0DE0005};
    exp_w[4] = {1'b1, 36'h5C0DE0006};
    reset_dut();
    nbins = 4'd3;
    run_seq(10, 64'h1, 64'h4, -1);
    drain();
    n_cmp++; if (got.size() !== 5) begin n_err++; $display("FAIL basic_count: got %0d words required 5", got.size()); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (k >= got.size() || got[k] !== exp_w[k]) begin
        n_err++;
        $display("FAIL basic_word%0d: got %h required %h", k, (k < got.size()) ? got[k] : 37'h0, exp_w[k]);
      end
    end
    n_cmp++; if (l1a_cnt !== 12'd1 || drop_cnt !== 8'd0) begin n_err++; $display("FAIL basic_cnts: l1a_cnt=%0d drop_cnt=%0d required 1 0", l1a_cnt, drop_cnt); end
  endtask

  task automatic test_valorr_zero();
    reset_dut();
    nbins = 4'd3;
    l1a = 1'b1; step();
    l1a = 1'b0; step();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL noval_busy_wait: got %b required 1", busy); end
    valorr = 1'b0; step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL noval_busy_idle: got %b required 0", busy); end
    step(); step();
    n_cmp++; if (rd.rd_valid !== 1'b0) begin n_err++; $display("FAIL noval_rd_valid: got %b required 0", rd.rd_valid); end
    n_cmp++; if (drop_cnt !== 8'd0 || l1a_cnt !== 12'd1) begin n_err++; $display("FAIL noval_cnts: drop_cnt=%0d l1a_cnt=%0d required 0 1", drop_cnt, l1a_cnt); end
  endtask

  task automatic test_full_drop();
    int nlast = 0;
    reset_dut();
    nbins = 4'd15;
    run_seq(30, 64'h100001, 64'h400004, -1);
    n_cmp++; if (drop_cnt !== 8'd1 || l1a_cnt !== 12'd2) begin n_err++; $display("FAIL full_cnts: drop_cnt=%0d l1a_cnt=%0d required 1 2", drop_cnt, l1a_cnt); end
    n_cmp++; if (rd.rd_valid !== 1'b1 || rd.rd_data !== 36'hA0010F000) begin n_err++; $display("FAIL full_head: valid=%b data=%h required 1 A0010F000", rd.rd_valid, rd.rd_data); end
    step(); step();
    n_cmp++; if (rd.rd_data !== 36'hA0010F000) begin n_err++; $display("FAIL full_hold: got %h required A0010F000", rd.rd_data); end
    drain();
    n_cmp++; if (got.size() !== 17) begin n_err++; $display("FAIL full_count: got %0d words required 17", got.size()); end
    if (got.size() == 17) begin
      n_cmp++; if (got[1] !== {1'b0, 36'h5C0DE0003}) begin n_err++; $display("FAIL full_first_frame: got %h required 05C0DE0003", got[1]); end
      n_cmp++; if (got[16] !== {1'b1, 36'h5C0DE0012}) begin n_err++; $display("FAIL full_last_frame: got %h required 15C0DE0012", got[16]); end
      foreach (got[k]) if (got[k][36]) nlast++;
      n_cmp++; if (nlast !== 1) begin n_err++; $display("FAIL full_last_tags: got %0d required 1", nlast); end
    end
  endtask

  task automatic test_cfg_abort();
    int n = 0;
    reset_dut();
    nbins = 4'd3;
    cfg_delay = 8'd40;
    run_seq(5, 64'h1, 64'h4, 4);
    n_cmp++; if (delay !== 8'd40) begin n_err++; $display("FAIL abort_delay: got %0d required 40", delay); end
    n_cmp++; if (trig_stop !== 1'b1 || we !== 1'b0) begin n_err++; $display("FAIL abort_stop1: trig_stop=%b we=%b required 1 0", trig_stop, we); end
    step();
    n_cmp++; if (trig_stop !== 1'b1) begin n_err++; $display("FAIL abort_stop2: got %b required 1", trig_stop); end
    step();
    n_cmp++; if (trig_stop !== 1'b0 || we !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL abort_refill: trig_stop=%b we=%b busy=%b required 0 1 1", trig_stop, we, busy); end
    for (int i = 0; i < 10; i++) step();
    cfg_delay = 8'd7;
    cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
    n_cmp++; if (trig_stop !== 1'b1 || delay !== 8'd7) begin n_err++; $display("FAIL restop: trig_stop=%b delay=%0d required 1 7", trig_stop, delay); end
    step();
    n_cmp++; if (trig_stop !== 1'b1) begin n_err++; $display("FAIL restop2: got %b required 1", trig_stop); end
    step();
    while (busy === 1'b1 && n < 400) begin
      n++;
      step();
    end
    n_cmp++; if (n !== 256) begin n_err++; $display("FAIL abort_refill_len: got %0d required 256", n); end
    drain();
    n_cmp++; if (got.size() !== 2) begin n_err++; $display("FAIL abort_count: got %0d words required 2", got.size()); end
    if (got.size() == 2) begin
      n_cmp++; if (got[0] !== {1'b0, 36'hA00103000}) begin n_err++; $display("FAIL abort_hdr: got %h required 0A00103000", got[0]); end
      n_cmp++; if (got[1] !== {1'b1, 36'h5C0DE0003}) begin n_err++; $display("FAIL abort_tail: got %h required 15C0DE0003", got[1]); end
    end
  endtask

  task automatic test_l1a_during_capture();
    logic [36:0] exp_w [5];
    exp_w[0] = {1'b0, 36'hA00103000};
    exp_w[1] = {1'b0, 36'h5C0DE0003};
    exp_w[2] = {1'b0, 36'h5C0DE0004};
    exp_w[3] = {1'b0, 36'h5C0DE0005};
    exp_w[4] = {1'b1, 36'h5C0DE0006};
    reset_dut();
    nbins = 4'd3;
    run_seq(10, 64'h53, 64'h4, -1);
    drain();
    n_cmp++; if (l1a_cnt !== 12'd4 || drop_cnt !== 8'd3) begin n_err++; $display("FAIL busy_l1a_cnts: l1a_cnt=%0d drop_cnt=%0d required 4 3", l1a_cnt, drop_cnt); end
    n_cmp++; if (got.size() !== 5) begin n_err++; $display("FAIL busy_l1a_count: got %0d words required 5", got.size()); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (k >= got.size() || got[k] !== exp_w[k]) begin
        n_err++;
        $display("FAIL busy_l1a_word%0d: got %h required %h", k, (k < got.size()) ? got[k] : 37'h0, exp_w[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [36:0] exp_w [6];
    exp_w[0] = {1'b0, 36'hA00101000};
    exp_w[1] = {1'b0, 36'h5C0DE0003};
    exp_w[2] = {1'b1, 36'h5C0DE0004};
    exp_w[3] = {1'b0, 36'hA00201000};
    exp_w[4] = {1'b0, 36'h5C0DE0008};
    exp_w[5] = {1'b1, 36'h5C0DE0009};
    reset_dut();
    nbins = 4'd1;
    rd.rd_ready = 1'b1;
    run_seq(14, 64'h21, 64'h84, -1);
    drain();
    n_cmp++; if (got.size() !== 6) begin n_err++; $display("FAIL b2b_count: got %0d words required 6", got.size()); end
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (k >= got.size() || got[k] !== exp_w[k]) begin
        n_err++;
        $display("FAIL b2b_word%0d: got %h required %h", k, (k < got.size()) ? got[k] : 37'h0, exp_w[k]);
      end
    end
    n_cmp++; if (drop_cnt !== 8'd0 || l1a_cnt !== 12'd2) begin n_err++; $display("FAIL b2b_cnts: drop_cnt=%0d l1a_cnt=%0d required 0 2", drop_cnt, l1a_cnt); end
  endtask

  task automatic test_reset_mid_capture();
    reset_dut();
    nbins = 4'd3;
    run_seq(5, 64'h1, 64'h4, -1);
    n_cmp++; if (rd.rd_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid: got %b required 1", rd.rd_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rd.rd_valid !== 1'b0 || busy !== 1'b1 || trig_stop !== 1'b1) begin n_err++; $display("FAIL midrst_async: valid=%b busy=%b trig_stop=%b required 0 1 1", rd.rd_valid, busy, trig_stop); end
    step(); step();
    rst_n = 1'b1;
    for (int n = 0; n < 400 && busy !== 1'b0; n++) step();
    drain();
    n_cmp++; if (got.size() !== 0) begin n_err++; $display("FAIL midrst_flushed: got %0d words required 0", got.size()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rd.rd_ready = 1'b0;
    test_reset();
    test_basic_event();
    test_valorr_zero();
    test_full_drop();
    test_cfg_abort();
    test_l1a_during_capture();
    test_back_to_back();
    test_reset_mid_capture();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/best_delay_readout_ctrl.md
BEST_DELAY_READOUT_CTRL -- requirements
Module: best_delay_readout_ctrl

Interface
REQ-001 Parameter VAL_LAT, default 2: cycles from l1a pulse to the cycle in which valorr is sampled.
REQ-002 Parameter FIFO_DEPTH, default 32: output FIFO depth in words (power of two).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 l1a  input  1  level-1 accept pulse, one cycle.
REQ-006 valorr  input  1  window-OR of valid from delay buffer.
REQ-007 buf_dout  input  36  delayed frame stream from delay buffer.
REQ-008 nbins  input  4  frames per readout minus one (1..16 frames).
REQ-009 cfg_delay  input  8  new delay value.
REQ-010 cfg_wr  input  1  pulse: apply cfg_delay.
REQ-011 delay  output  8  registered delay to buffer.
REQ-012 trig_stop  output  1  buffer flush/stop.
REQ-013 we  output  1  buffer write enable.
REQ-014 rd_data  output  36  readout word; rd_valid output 1; rd_ready input 1; rd_last output 1 (last word of event).
REQ-015 busy  output  1  state is not IDLE; l1a_cnt output 12; drop_cnt output 8.

Function
REQ-016 States: IDLE, WAIT_VAL, CAPTURE, STOP, REFILL.
REQ-017 IDLE + l1a -> WAIT_VAL, cycle counter loaded; l1a_cnt increments on every l1a, wraps at 4095->0.
REQ-018 WAIT_VAL: valorr sampled exactly VAL_LAT cycles after the l1a cycle; valorr=0 -> IDLE, nothing written.
REQ-019 valorr=1 and FIFO free >= nbins+2 -> header written that cycle: {4'hA, l1a_cnt[11:0] of the triggering l1a, 4'h0, nbins, 12'h000}; -> CAPTURE.
REQ-020 valorr=1 and FIFO free < nbins+2 -> drop_cnt increments, -> IDLE, nothing written.
REQ-021 CAPTURE: buf_dout written on each of the next nbins+1 cycles; the last frame is tagged last; -> IDLE after the last frame.
REQ-022 l1a while state != IDLE: counted in l1a_cnt and drop_cnt, otherwise ignored; l1a in the same cycle as the IDLE return is also dropped.
REQ-023 drop_cnt saturates at 255.
REQ-024 cfg_wr in any state: delay <= cfg_delay next cycle; -> STOP; any capture in progress is aborted; the header and frames already written remain, and the last written word is forced last.
REQ-025 STOP: trig_stop=1, we=0, for exactly 2 cycles, then -> REFILL.
REQ-026 REFILL: 256 cycles, we=1, l1a dropped, then -> IDLE; cfg_wr during REFILL restarts STOP.
REQ-027 we=1 in all states except STOP.
REQ-028 FIFO: first-word-fall-through; a word transfers when rd_valid and rd_ready are both 1; simultaneous write and read at full is not possible because of the REQ-019 precheck.
REQ-029 rd_valid, rd_data and rd_last reflect the FIFO head; rd_data is held stable while rd_valid=1 and rd_ready=0.

Reset
REQ-030 rst_n low: state IDLE; FIFO empty; rd_valid=0; rd_last=0; rd_data=0; delay=8'd0; trig_stop=1; we=0; l1a_cnt=0; drop_cnt=0; busy=1.
REQ-031 After rst_n deasserts, the block enters STOP (2 cycles), then REFILL, then IDLE.
REQ-032 rst_n asserted mid-capture discards all FIFO contents.

Structure
REQ-033 Package best_delay_pkg holds: state enum, header marker 4'hA, frame width 36, REFILL_CYCLES=256, STOP_CYCLES=2.
REQ-034 Sub-module readout_fifo: synchronous FIFO, 37 bits wide (data + last), FIFO_DEPTH deep, with a free-count output.

Verification
REQ-035 Reset release -> trig_stop=1 for 2 cycles, then busy=1 for 256 cycles, then busy=0.
REQ-036 nbins=3, l1a at t, valorr=1 at t+2 -> 5 words read: header A,l1a_cnt=1,nbins=3, then 4 frames equal to buf_dout at t+3..t+6; rd_last on word 5.
REQ-037 valorr=0 at t+2 -> no words, drop_cnt unchanged, busy=0 at t+3.
REQ-038 rd_ready=0, repeated nbins=15 events -> first event accepted (17 words), second dropped (free 15 < 17), drop_cnt=1.
REQ-039 cfg_wr=1 with cfg_delay=8'd40 during CAPTURE of frame 2 -> delay=40 next cycle, last written word tagged last, trig_stop for 2 cycles, then 256 REFILL cycles.
REQ-040 l1a during CAPTURE -> l1a_cnt +1, drop_cnt +1, event output unchanged.
